// File: rtl/fc_stream_host_if.sv
// fc_stream_host_if
//   Groups the two streaming channels between the host endpoint and a
//   fully-connected layer.
//   tx_*    : host -> layer input vector channel (input_valid/ready/data)
//   rx_*    : layer -> host result channel (output_valid/ready/data)
//   rx_hold : request from the environment to stall the result channel
//   master  : host side (fc_stream_host)
//   slave   : layer side (layer model / testbench)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The source holds valid high and data stable until that
// edge. The sink may raise or lower ready at any time. At most one
// element moves per cycle on each channel.
interface fc_stream_host_if #(
    parameter int T = 8
);
    logic         tx_valid;
    logic         tx_ready;
    logic [T-1:0] tx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [T-1:0] rx_data;
    logic         rx_hold;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data, rx_hold
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data, rx_hold
    );
endinterface

// File: rtl/fc_stream_host.sv
// fc_stream_host
//   Host-side endpoint for a streaming fully-connected layer. A parallel
//   load port fills an N-entry vector buffer. On start, the block streams
//   the N elements out on bus.tx_*. It then collects M results from bus.rx_*
//   into an M-entry result buffer, which can be read by address.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   load_en/addr/data : vector buffer write port (IDLE only, addr >= N ignored)
//   start             : begin a transaction (IDLE only)
//   busy              : state is not IDLE
//   done              : one-cycle pulse after the last result is stored
//   state_dbg         : current FSM state encoding (IDLE=0 SEND=1 RECV=2 DONE=3)
//   bus               : tx/rx streaming channels (master modport)
//   rd_addr / rd_data : combinational result buffer read (0 when addr >= M)
module fc_stream_host #(
    parameter int M = 6,
    parameter int N = 6,
    parameter int T = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load_en,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] load_addr,
    input  logic [T-1:0]                        load_data,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          state_dbg,
    fc_stream_host_if.master                    bus,
    input  logic [((M > 1) ? $clog2(M) : 1)-1:0] rd_addr,
    output logic [T-1:0]                        rd_data
);
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int MW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [NW-1:0]   tx_cnt;
    logic [MW-1:0]   rx_cnt;
    logic            tx_valid_q;
    logic [T-1:0]    vec [N];
    logic [T-1:0]    res [M];
    logic            rx_ready_c;

    // rx_ready must react to rx_hold in the same cycle, so it is
    // decoded from state rather than registered.
    assign rx_ready_c   = (state == RECV) && !bus.rx_hold;
    assign bus.rx_ready = rx_ready_c;

    // tx_data is forced to 0 outside SEND so the port is quiet while the
    // buffer is being loaded.
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_valid_q ? vec[tx_cnt] : '0;

    assign rd_data   = (int'(rd_addr) < M) ? res[rd_addr] : '0;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            tx_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < N; i++) vec[i] <= '0;
            for (int i = 0; i < M; i++) res[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A write and a start in the same cycle both take
                    // effect: element 0 is read from vec only in SEND.
                    if (load_en && (int'(load_addr) < N))
                        vec[load_addr] <= load_data;
                    if (start) begin
                        state      <= SEND;
                        tx_cnt     <= '0;
                        rx_cnt     <= '0;
                        tx_valid_q <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SEND: begin
                    if (tx_valid_q && bus.tx_ready) begin
                        // The counter stops at N-1 so vec is never
                        // indexed out of range.
                        if (tx_cnt == NW'(N - 1)) begin
                            state      <= RECV;
                            tx_valid_q <= 1'b0;
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (bus.rx_valid && rx_ready_c) begin
                        res[rx_cnt] <= bus.rx_data;
                        if (rx_cnt == MW'(M - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    tx_valid_q <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/fc_stream_host.md
# fc_stream_host

Host-side endpoint for the streaming fully-connected layers: it drives the layer's input vector port and collects its output port. A parallel load port fills an N-entry vector buffer. On `start`, the block transmits the N elements over a valid/ready channel into the layer's `input_valid`/`input_ready`/`input_data`. It then accepts M results from the layer's `output_valid`/`output_ready`/`output_data` into an M-entry result buffer readable by address.

## Interface

Parameters:
- M, 6, number of result elements (layer output length)
- N, 6, number of vector elements (layer input length)
- T, 8, element width in bits (signed two's complement)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- load_en  input  1  write `load_data` to `vec[load_addr]`; honoured only in IDLE
- load_addr  input  $clog2(N)  vector buffer write address; values ≥ N are ignored (no write)
- load_data  input  T  vector element to write
- start  input  1  begin a transaction; sampled only in IDLE
- busy  output  1  high whenever the state is not IDLE
- done  output  1  one-cycle pulse when all M results are stored
- tx_valid  output  1  element available on `tx_data` (to layer `input_valid`)
- tx_ready  input  1  layer accepts element (from layer `input_ready`)
- tx_data  output  T  `vec[tx_cnt]` (to layer `input_data`)
- rx_valid  input  1  layer result available (from layer `output_valid`)
- rx_ready  output  1  block accepts result (to layer `output_ready`)
- rx_data  input  T  layer result (from layer `output_data`)
- rx_hold  input  1  backpressure request; forces `rx_ready` low
- rd_addr  input  $clog2(M)  result buffer read address
- rd_data  output  T  combinational `res[rd_addr]`; 0 when rd_addr ≥ M

## Operation

- Storage:
  - `vec[0..N-1]` and `res[0..M-1]` are T-bit registers, cleared by reset.
  - `tx_cnt` counts 0..N-1 and `rx_cnt` counts 0..M-1; both are cleared by reset and on entry to SEND.
- States: IDLE, SEND, RECV, DONE.
- IDLE:
  - `tx_valid`=0, `rx_ready`=0.
  - `load_en` writes the vector buffer.
  - `start`=1 → SEND.
- SEND:
  - `tx_valid`=1, `tx_data`=`vec[tx_cnt]`.
  - A transfer occurs on `tx_valid & tx_ready`, which increments `tx_cnt`.
  - The transfer with `tx_cnt`=N-1 → RECV.
  - `rx_ready`=0 throughout SEND.
- RECV:
  - `tx_valid`=0, `rx_ready`=~`rx_hold`.
  - On `rx_valid & rx_ready`: `res[rx_cnt]` ← `rx_data` and `rx_cnt` increments.
  - The transfer with `rx_cnt`=M-1 → DONE.
- DONE:
  - `done`=1 for exactly one cycle, `rx_ready`=0.
  - → IDLE unconditionally.
- Data is stored bit-exact with no sign extension or saturation.
- `load_en` and `start` in the same IDLE cycle: the write lands at that edge, and element 0 sent afterwards reflects the new value.
- `start` or `load_en` outside IDLE: ignored, with no queuing.
- Reset asserted mid-transaction:
  - Immediately forces IDLE and clears all outputs, counters and buffers.
  - The partial transaction is abandoned and `done` does not pulse.
- `rd_data` is valid in every state. During RECV it shows partially updated results; entries not yet written hold their previous transaction's values.

## Timing

- Reset values: `busy`=0, `done`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=0, `rd_data`=0.
- `start` sampled at edge k → `tx_valid`=1 and `busy`=1 from cycle k+1.
- `tx_valid` never drops before acceptance.
- `tx_data` is held stable while `tx_valid & ~tx_ready`.
- At most one transfer per cycle on each channel.
- Back-to-back acceptance:
  - Element i+1 is presented the cycle after element i is accepted, so there are no bubbles in SEND.
  - `rx_ready` stays high through consecutive RECV cycles when `rx_hold`=0.
- `rx_hold` has zero-cycle effect on `rx_ready`, which is combinational from state and `rx_hold`.
- Minimum transaction: N cycles SEND + M cycles RECV + 1 cycle DONE; a new `start` is accepted the cycle after DONE.
- A stored result is readable on `rd_data` the cycle after its rx transfer.

## Test plan

- Reset defaults:
  - Assert reset asynchronously mid-cycle → all outputs 0 immediately.
  - Then `rd_addr`=0..5 → `rd_data`=0.
- Basic transaction:
  - Stimulus: load vec={1,2,3,4,5,6}, pulse `start`, `tx_ready`=1; a responder returns {10,-20,30,-40,50,-60} with `rx_valid`=1.
  - `tx_data` sequence is 1..6 on 6 consecutive cycles.
  - `done` pulses 13 cycles after `start`.
  - `rd_data` reads back {10,-20,30,-40,50,-60}, e.g. -20 as 8'hEC.
- Backpressure both ways:
  - Stimulus: random `tx_ready` and `rx_hold` toggling.
  - `tx_data` stays stable while unaccepted.
  - Exactly 6 transfers occur on each side.
  - Results are stored in order with no loss or duplication.
- Ignored controls:
  - Stimulus: `load_en` writing vec[0]=99 and a second `start` during SEND.
  - The transaction still sends the original vec[0]=1.
  - Exactly one `done` pulse is produced.
  - A following transaction sends 1 again.
- Same-cycle load and start:
  - `load_en` with addr 0 and data -7, together with `start` → first `tx_data`=-7 (8'hF9).
- Reset mid-RECV:
  - Stimulus: assert reset after 3 results are accepted.
  - No `done` pulse.
  - `res` reads all 0.
  - A fresh transaction completes normally.
